// File: rtl/leaf_out_packetizer_if.sv
// Handshake and BFT bus bundle between an HLS kernel, the leaf packetizer and the switch port.
// The master side drives the user streams, incoming control packets and back-pressure.
interface leaf_out_packetizer_if #(
    parameter int NUM_OUT_PORTS = 2,
    parameter int PAYLOAD_BITS  = 32,
    parameter int PACKET_BITS   = 49
);
    logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user;
    logic [NUM_OUT_PORTS-1:0]              vld_user;
    logic [NUM_OUT_PORTS-1:0]              ack_user;
    logic [PACKET_BITS-1:0]                din_bft;
    logic                                  stall_bft;
    logic [PACKET_BITS-1:0]                dout_bft;
    logic [NUM_OUT_PORTS-1:0]              cfg_done;

    modport master (
        output din_user, vld_user, din_bft, stall_bft,
        input  ack_user, dout_bft, cfg_done
    );

    modport slave (
        input  din_user, vld_user, din_bft, stall_bft,
        output ack_user, dout_bft, cfg_done
    );
endinterface

// File: rtl/leaf_out_packetizer.sv
// Transmit-side leaf packetizer: round-robin over credited, configured user streams,
// stamping each word with its destination into a registered BFT packet.
module leaf_out_packetizer #(
    parameter int PACKET_BITS   = 49,
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_LEAF_BITS = 5,
    parameter int NUM_PORT_BITS = 4,
    parameter int NUM_ADDR_BITS = 7,
    parameter int NUM_OUT_PORTS = 2,
    parameter int CREDIT_INIT   = 128,
    parameter int SELF_LEAF     = 0
) (
    input  logic                  clk_bft,
    input  logic                  reset,
    leaf_out_packetizer_if.slave  bus
);

    localparam int PW       = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
    localparam int CW       = $clog2(CREDIT_INIT + 1);
    localparam int SW       = CW + 9;
    localparam int PORT_LSB = PAYLOAD_BITS + NUM_ADDR_BITS;

    localparam logic [3:0]    OP_CONFIG   = 4'h1;
    localparam logic [3:0]    OP_CREDIT   = 4'h2;
    localparam logic [3:0]    NUM_PORTS_4 = 4'(NUM_OUT_PORTS);
    localparam logic [SW-1:0] CREDIT_MAX  = SW'(CREDIT_INIT);
    localparam logic [CW-1:0] CREDIT_RST  = CW'(CREDIT_INIT);
    localparam logic [4:0]    SELF_ADDR   = 5'(SELF_LEAF);
    localparam logic [PW-1:0] LAST_PORT   = PW'(NUM_OUT_PORTS - 1);

    logic [PAYLOAD_BITS-1:0]  ctrl_payload;
    logic                     ctrl_hit;
    logic [3:0]               ctrl_op;
    logic [3:0]               ctrl_idx;
    logic                     cfg_we;
    logic                     credit_we;

    logic [NUM_LEAF_BITS-1:0] dest_leaf  [NUM_OUT_PORTS];
    logic [NUM_PORT_BITS-1:0] dest_port  [NUM_OUT_PORTS];
    logic [CW-1:0]            credit     [NUM_OUT_PORTS];
    logic [CW-1:0]            credit_nxt [NUM_OUT_PORTS];
    logic [NUM_OUT_PORTS-1:0] cfg_done;
    logic [NUM_OUT_PORTS-1:0] elig;
    logic [NUM_OUT_PORTS-1:0] ack;

    logic [PW-1:0]            rr_ptr;
    logic [PW-1:0]            grant_idx;
    logic                     grant_vld;
    logic [PW:0]              cand;
    logic [SW-1:0]            credit_sum;
    logic [3:0]               grant_idx_4;
    logic [NUM_ADDR_BITS-1:0] grant_addr;
    logic [PAYLOAD_BITS-1:0]  grant_word;
    logic [PACKET_BITS-1:0]   dout;

    // Control packets are valid BFT packets addressed to port 0 of this leaf.
    assign ctrl_payload = bus.din_bft[PAYLOAD_BITS-1:0];
    assign ctrl_hit     = bus.din_bft[PACKET_BITS-1] &&
                          (bus.din_bft[PORT_LSB +: NUM_PORT_BITS] == '0);
    assign ctrl_op      = ctrl_payload[31:28];
    assign ctrl_idx     = ctrl_payload[3:0];
    assign cfg_we       = ctrl_hit && (ctrl_op == OP_CONFIG) && (ctrl_idx < NUM_PORTS_4);
    assign credit_we    = ctrl_hit && (ctrl_op == OP_CREDIT) && (ctrl_idx < NUM_PORTS_4);

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            elig[i] = bus.vld_user[i] && cfg_done[i] && (credit[i] != '0) && !bus.stall_bft;
        end
    end

    // Scan eligible ports starting at the pointer, wrapping past the last port.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_OUT_PORTS; k++) begin
            cand = {1'b0, rr_ptr} + (PW+1)'(k);
            if (cand >= (PW+1)'(NUM_OUT_PORTS)) begin
                cand = cand - (PW+1)'(NUM_OUT_PORTS);
            end
            if (!grant_vld && elig[cand[PW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        ack = '0;
        if (grant_vld) begin
            ack[grant_idx] = 1'b1;
        end
    end

    // Return is added before the grant is taken off so a port at credit 1 never wraps.
    always_comb begin
        credit_sum = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            credit_sum = SW'(credit[i]);
            if (credit_we && (ctrl_idx == 4'(i))) begin
                credit_sum = credit_sum + SW'(ctrl_payload[15:8]);
            end
            if (ack[i]) begin
                credit_sum = credit_sum - SW'(1);
            end
            credit_nxt[i] = (credit_sum > CREDIT_MAX) ? CREDIT_RST : credit_sum[CW-1:0];
        end
    end

    assign grant_idx_4 = 4'(grant_idx);
    assign grant_addr  = {SELF_ADDR, grant_idx_4[1:0]};
    assign grant_word  = bus.din_user[int'(grant_idx)*PAYLOAD_BITS +: PAYLOAD_BITS];

    always_ff @(posedge clk_bft or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                dest_leaf[i] <= '0;
                dest_port[i] <= '0;
                credit[i]    <= CREDIT_RST;
            end
            cfg_done <= '0;
        end else begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                credit[i] <= credit_nxt[i];
                if (cfg_we && (ctrl_idx == 4'(i))) begin
                    dest_leaf[i] <= ctrl_payload[8:4];
                    dest_port[i] <= ctrl_payload[12:9];
                    cfg_done[i]  <= 1'b1;
                end
            end
        end
    end

    // Idle cycles only drop the valid bit; the rest of the last packet is left in place.
    always_ff @(posedge clk_bft or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
            dout   <= '0;
        end else if (grant_vld) begin
            rr_ptr <= (grant_idx == LAST_PORT) ? '0 : grant_idx + PW'(1);
            dout   <= {1'b1, dest_leaf[grant_idx], dest_port[grant_idx], grant_addr, grant_word};
        end else begin
            dout[PACKET_BITS-1] <= 1'b0;
        end
    end

    assign bus.ack_user = ack;
    assign bus.dout_bft = dout;
    assign bus.cfg_done = cfg_done;

endmodule
